// File: rtl/shift_step_sequencer.sv
// shift_step_sequencer
// Command stage in front of a 4-bit combinational shifter. A request for a
// shift of up to 2**AMT_W-1 positions is broken into steps of at most 3. Each
// step drives the shifter once and captures its output back into the
// accumulator, so the shifter itself only ever sees sel in 0..3. The final
// word is then held on a valid/ready result port.
module shift_step_sequencer #(
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_data,
    input  logic [AMT_W-1:0] req_amt,
    input  logic             req_dir,
    input  logic             req_op,
    output logic [3:0]       sh_d_in,
    output logic [1:0]       sh_sel,
    output logic             sh_dir,
    output logic             sh_op,
    input  logic [3:0]       sh_d_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_data,
    output logic             busy
);

    // Two spare bits let the remaining-amount arithmetic be done without
    // truncation for any AMT_W, including widths narrower than a step.
    localparam int EW = AMT_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       acc_q, acc_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             op_q, op_d;

    logic [1:0]       step;
    logic [EW-1:0]    rem_left;

    // Largest step the shifter can take this cycle: min(remaining, 3).
    function automatic logic [1:0] step_of(input logic [AMT_W-1:0] r);
        logic [EW-1:0] e;
        e = EW'(r);
        if (e >= EW'(3)) begin
            return 2'd3;
        end
        return e[1:0];
    endfunction

    // Step amount for the current cycle and the amount still owed after it.
    always_comb begin
        step     = (state_q == ST_RUN) ? step_of(rem_q) : 2'd0;
        rem_left = EW'(rem_q) - EW'(step);
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    acc_d   = req_data;
                    rem_d   = req_amt;
                    dir_d   = req_dir;
                    op_d    = req_op;
                    state_d = (req_amt == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // step never exceeds rem, so rem_left cannot wrap.
                acc_d = sh_d_out;
                rem_d = rem_left[AMT_W-1:0];
                if (rem_left == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset discards any in-flight request or pending result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= 4'd0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            op_q    <= op_d;
        end
    end

    // All outputs are decoded from registered state only.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        res_valid = (state_q == ST_DONE);
        res_data  = acc_q;
        sh_d_in   = acc_q;
        sh_sel    = step;
        sh_dir    = dir_q;
        sh_op     = op_q;
    end

endmodule

// File: tb/tb_shift_step_sequencer.sv
// Bench for shift_step_sequencer: a behavioural 4-bit shifter closes the
// feedback loop, directed requests push hand-computed results into a
// scoreboard, and a monitor pops them when a result is presented.
module tb_shift_step_sequencer;

    localparam int AMT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_data;
    logic [AMT_W-1:0] req_amt;
    logic             req_dir;
    logic             req_op;
    logic [3:0]       sh_d_in;
    logic [1:0]       sh_sel;
    logic             sh_dir;
    logic             sh_op;
    logic [3:0]       sh_d_out;
    logic             res_valid;
    logic             res_ready;
    logic [3:0]       res_data;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [3:0] data;
        int         first_cyc;
    } exp_t;

    exp_t sb_q[$];

    shift_step_sequencer #(.AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_dir   (req_dir),
        .req_op    (req_op),
        .sh_d_in   (sh_d_in),
        .sh_sel    (sh_sel),
        .sh_dir    (sh_dir),
        .sh_op     (sh_op),
        .sh_d_out  (sh_d_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational 4-bit shifter the sequencer drives.
    always_comb begin
        logic [7:0] dd;
        logic [7:0] t;
        dd = {sh_d_in, sh_d_in};
        t  = 8'd0;
        if (sh_op) begin
            if (sh_dir) begin
                t = dd >> sh_sel;
                sh_d_out = t[3:0];
            end else begin
                t = dd << sh_sel;
                sh_d_out = t[7:4];
            end
        end else begin
            sh_d_out = sh_dir ? (sh_d_in >> sh_sel) : (sh_d_in << sh_sel);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it through RUN and DONE.
    task automatic run_req(input logic [3:0] d, input logic [2:0] a,
                           input logic dir, input logic op,
                           input logic [3:0] exp_res, input int nsteps,
                           input logic [5:0] sels, input logic [11:0] accs,
                           input int hold, input string tag);
        int   n;
        exp_t e;
        res_ready = (hold == 0);
        step();
        req_data  = d;
        req_amt   = a;
        req_dir   = dir;
        req_op    = op;
        req_valid = 1'b1;
        #1;
        chk({tag, "_req_ready"}, int'(req_ready), 1);
        n = cyc + 1;
        e.data      = exp_res;
        e.first_cyc = n + nsteps;
        sb_q.push_back(e);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < nsteps; i++) begin
            #1;
            chk({tag, "_sel"},   int'(sh_sel),  int'(sels[5-2*i -: 2]));
            chk({tag, "_d_in"},  int'(sh_d_in), int'(accs[11-4*i -: 4]));
            chk({tag, "_dir"},   int'(sh_dir),  int'(dir));
            chk({tag, "_op"},    int'(sh_op),   int'(op));
            chk({tag, "_busy"},  int'(busy),    1);
            step();
        end
        #1;
        chk({tag, "_done_valid"}, int'(res_valid), 1);
        chk({tag, "_done_sel"},   int'(sh_sel),    0);
        chk({tag, "_done_busy"},  int'(busy),      1);
        if (hold > 0) begin
            for (int h = 1; h < hold; h++) begin
                step();
                req_valid = 1'b1;
                req_data  = ~d;
                req_amt   = 3'd1;
                #1;
                chk({tag, "_hold_valid"}, int'(res_valid), 1);
                chk({tag, "_hold_ready"}, int'(req_ready), 0);
            end
            step();
            req_valid = 1'b0;
            res_ready = 1'b1;
            #1;
            chk({tag, "_hold_last"}, int'(res_valid), 1);
        end
        step();
        #1;
        chk({tag, "_idle_ready"}, int'(req_ready), 1);
        chk({tag, "_idle_valid"}, int'(res_valid), 0);
        chk({tag, "_idle_busy"},  int'(busy),      0);
    endtask

    // Monitor: pop the scoreboard when a result appears, check latency and
    // that the data stays stable until it is taken.
    initial begin
        exp_t cur;
        bit   in_res;
        in_res = 1'b0;
        cur.data = 4'd0;
        cur.first_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid) begin
                if (!in_res) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_result", int'(res_data), -1);
                    end else begin
                        cur = sb_q.pop_front();
                        chk("res_latency", cyc, cur.first_cyc);
                    end
                    in_res = 1'b1;
                end
                chk("res_data", int'(res_data), int'(cur.data));
                if (res_ready) in_res = 1'b0;
            end else begin
                in_res = 1'b0;
            end
        end
    end

    // Stimulus.
    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_data  = 4'd0;
        req_amt   = '0;
        req_dir   = 1'b0;
        req_op    = 1'b0;
        res_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_sh_sel",    int'(sh_sel),    0);
        chk("rst_sh_d_in",   int'(sh_d_in),   0);
        chk("rst_sh_dir",    int'(sh_dir),    0);
        chk("rst_sh_op",     int'(sh_op),     0);

        run_req(4'b0011, 3'd5, 1'b0, 1'b0, 4'b0000, 2, 6'b11_10_00, 12'b0011_1000_0000, 0, "ll5");
        run_req(4'b1000, 3'd5, 1'b1, 1'b1, 4'b0100, 2, 6'b11_10_00, 12'b1000_0001_0000, 0, "rr5");
        run_req(4'b0110, 3'd7, 1'b0, 1'b1, 4'b0011, 3, 6'b11_11_01, 12'b0110_0011_1001, 0, "rl7");
        run_req(4'b1010, 3'd0, 1'b1, 1'b1, 4'b1010, 0, 6'b00_00_00, 12'b0000_0000_0000, 0, "amt0");
        run_req(4'b1101, 3'd4, 1'b1, 1'b0, 4'b0000, 2, 6'b11_01_00, 12'b1101_0001_0000, 0, "lr4");
        run_req(4'b0101, 3'd2, 1'b0, 1'b0, 4'b0100, 1, 6'b10_00_00, 12'b0101_0000_0000, 4, "hold");

        // Reset in the middle of a long rotate.
        step();
        req_data  = 4'b1111;
        req_amt   = 3'd7;
        req_dir   = 1'b0;
        req_op    = 1'b1;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        #1;
        chk("rstrun_busy", int'(busy), 1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("rstrun_req_ready", int'(req_ready), 1);
        chk("rstrun_res_valid", int'(res_valid), 0);
        chk("rstrun_busy",      int'(busy),      0);
        chk("rstrun_sh_d_in",   int'(sh_d_in),   0);
        chk("rstrun_sh_sel",    int'(sh_sel),    0);

        run_req(4'b1011, 3'd6, 1'b1, 1'b1, 4'b1110, 2, 6'b11_11_00, 12'b1011_0111_0000, 0, "rr6");
        run_req(4'b1010, 3'd1, 1'b1, 1'b0, 4'b0101, 1, 6'b01_00_00, 12'b1010_0000_0000, 0, "lr1");

        repeat (3) step();
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_checks, n_pass);
        $fatal(1, "watchdog expired");
    end

endmodule
